// File: rtl/quad_input_conditioner_pkg.sv
// Shared definitions for the rotary-encoder front-end: AB Gray states,
// direction codes seen by the game engine, and the quadrature step decoder.
package quad_input_conditioner_pkg;

    // Encoder AB states, named by {A,B}
    typedef enum logic [1:0] {
        ST_00 = 2'b00,
        ST_01 = 2'b01,
        ST_11 = 2'b11,
        ST_10 = 2'b10
    } ab_state_t;

    // Rotation direction codes, shared with the game engine
    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_CW   = 2'b01,
        DIR_ACW  = 2'b10
    } dir_t;

    // One decoded quadrature observation
    typedef struct packed {
        logic illegal;
        dir_t dir;
    } step_t;

    // Signed step accumulator width
    localparam int unsigned ACC_WIDTH = 4;

    // Next state along the clockwise sequence 00->01->11->10->00
    function automatic ab_state_t cw_successor(input ab_state_t s);
        ab_state_t r;
        case (s)
            ST_01:   r = ST_11;
            ST_11:   r = ST_10;
            ST_10:   r = ST_00;
            default: r = ST_01;
        endcase
        return r;
    endfunction

    // Classify the move from prev to cur: hold, one CW step, one ACW step,
    // or illegal (both channels changed at once)
    function automatic step_t decode_step(input ab_state_t prev, input ab_state_t cur);
        step_t r;
        r.illegal = 1'b0;
        r.dir     = DIR_NONE;
        if (cur != prev) begin
            if (cur == cw_successor(prev)) begin
                r.dir = DIR_CW;
            end else if (prev == cw_successor(cur)) begin
                r.dir = DIR_ACW;
            end else begin
                r.illegal = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/quad_input_conditioner_if.sv
// Pin/output bundle between the encoder front-end and its user.
interface quad_input_conditioner_if #(
    parameter int unsigned POS_WIDTH = 4
);
    logic                 a_in;
    logic                 b_in;
    logic                 c_in;
    logic                 clr_in;
    logic                 cw_out;
    logic                 acw_out;
    logic                 btn_out;
    logic                 err_out;
    logic [POS_WIDTH-1:0] pos_out;

    // Board/engine side: drives raw pins and clear, consumes events
    modport master (
        output a_in, b_in, c_in, clr_in,
        input  cw_out, acw_out, btn_out, err_out, pos_out
    );

    // Conditioner side
    modport slave (
        input  a_in, b_in, c_in, clr_in,
        output cw_out, acw_out, btn_out, err_out, pos_out
    );
endinterface

// File: rtl/quad_input_conditioner_debounce_filter.sv
// Two-flop synchroniser followed by a counter-based debouncer for one
// raw asynchronous pin. A new level is accepted only after the synced pin
// has differed from the stable value for DEBOUNCE_CYCLES consecutive cycles.
module debounce_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic raw_in,
    output logic stable_out
);

    localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Synchronise the pin, then count consecutive disagreeing cycles
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync1      <= RESET_VAL;
            sync2      <= RESET_VAL;
            stable_out <= RESET_VAL;
            cnt        <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            if (sync2 != stable_out) begin
                if (cnt == CNT_LAST) begin
                    stable_out <= sync2;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/quad_input_conditioner.sv
// Rotary-encoder front-end: debounces A/B/C, decodes quadrature at 4x,
// emits per-detent cw/acw pulses, a button-press pulse, an illegal-move
// pulse, and keeps a saturating cursor position.
module quad_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000,
    parameter int unsigned COUNTS_PER_DETENT = 4,
    parameter int unsigned POS_WIDTH         = 4,
    parameter int unsigned POS_MAX           = 15
) (
    input logic                      clk_in,
    input logic                      rst_in,
    quad_input_conditioner_if.slave  bus
);
    import quad_input_conditioner_pkg::*;

    localparam logic signed [ACC_WIDTH-1:0] ACC_DETENT     = ACC_WIDTH'(COUNTS_PER_DETENT);
    localparam logic signed [ACC_WIDTH-1:0] ACC_DETENT_NEG = -ACC_DETENT;
    localparam logic [POS_WIDTH-1:0]        POS_LIMIT      = POS_WIDTH'(POS_MAX);

    logic a_stable;
    logic b_stable;
    logic c_stable;

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       (1'b1)
    ) u_deb_a (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .raw_in     (bus.a_in),
        .stable_out (a_stable)
    );

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       (1'b1)
    ) u_deb_b (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .raw_in     (bus.b_in),
        .stable_out (b_stable)
    );

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       (1'b0)
    ) u_deb_c (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .raw_in     (bus.c_in),
        .stable_out (c_stable)
    );

    ab_state_t                    ab_cur;
    ab_state_t                    ab_prev;
    step_t                        step;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  acc_step;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic [POS_WIDTH-1:0]         pos;
    logic [POS_WIDTH-1:0]         pos_next;
    logic                         cw_next;
    logic                         acw_next;
    logic                         err_next;
    logic                         c_prev;
    logic                         cw_r;
    logic                         acw_r;
    logic                         btn_r;
    logic                         err_r;

    assign ab_cur = ab_state_t'({a_stable, b_stable});

    // Decode the stable AB move, advance the accumulator, detect detents,
    // and update position; clear overrides everything including the pulse
    always_comb begin
        step     = decode_step(ab_prev, ab_cur);
        acc_next = acc;
        acc_step = acc;
        pos_next = pos;
        cw_next  = 1'b0;
        acw_next = 1'b0;
        err_next = step.illegal;

        if (step.illegal) begin
            acc_next = '0;
        end else if (step.dir == DIR_CW) begin
            acc_step = acc + 4'sd1;
            if (acc_step == ACC_DETENT) begin
                cw_next  = 1'b1;
                acc_next = '0;
            end else begin
                acc_next = acc_step;
            end
        end else if (step.dir == DIR_ACW) begin
            acc_step = acc - 4'sd1;
            if (acc_step == ACC_DETENT_NEG) begin
                acw_next = 1'b1;
                acc_next = '0;
            end else begin
                acc_next = acc_step;
            end
        end

        if (bus.clr_in) begin
            acc_next = '0;
            pos_next = '0;
            cw_next  = 1'b0;
            acw_next = 1'b0;
        end else if (cw_next && (pos != POS_LIMIT)) begin
            pos_next = pos + POS_WIDTH'(1);
        end else if (acw_next && (pos != '0)) begin
            pos_next = pos - POS_WIDTH'(1);
        end
    end

    // Register decoder state and all outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ab_prev <= ST_11;
            c_prev  <= 1'b0;
            acc     <= '0;
            pos     <= '0;
            cw_r    <= 1'b0;
            acw_r   <= 1'b0;
            btn_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ab_prev <= ab_cur;
            c_prev  <= c_stable;
            acc     <= acc_next;
            pos     <= pos_next;
            cw_r    <= cw_next;
            acw_r   <= acw_next;
            btn_r   <= c_stable & ~c_prev;
            err_r   <= err_next;
        end
    end

    assign bus.cw_out  = cw_r;
    assign bus.acw_out = acw_r;
    assign bus.btn_out = btn_r;
    assign bus.err_out = err_r;
    assign bus.pos_out = pos;

endmodule

// File: tb/tb_quad_input_conditioner.sv
// Directed bench for quad_input_conditioner with short debounce.
module tb_quad_input_conditioner;

    logic clk;
    logic rst_n;

    quad_input_conditioner_if #(.POS_WIDTH(4)) bus ();

    quad_input_conditioner #(
        .DEBOUNCE_CYCLES   (8),
        .COUNTS_PER_DETENT (4),
        .POS_WIDTH         (4),
        .POS_MAX           (15)
    ) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ab;
        logic       c;
        logic       clr;
        int         cyc;
        int         ecw;
        int         eacw;
        int         eerr;
        int         ebtn;
        int         epos;
    } vec_t;

    vec_t vecs[$];
    int   seg_a_end;
    logic [1:0] hand_ab;

    int checks = 0;
    int errors = 0;

    // build-time model of the encoder
    logic [1:0] m_ab;
    int         m_acc;
    int         m_pos;

    // output pulse monitor
    int   n_cw = 0, n_acw = 0, n_err = 0, n_btn = 0, n_excl = 0, n_wide = 0;
    logic l_cw = 1'b0, l_acw = 1'b0, l_err = 1'b0, l_btn = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cw_out)  n_cw  <= n_cw + 1;
            if (bus.acw_out) n_acw <= n_acw + 1;
            if (bus.err_out) n_err <= n_err + 1;
            if (bus.btn_out) n_btn <= n_btn + 1;
            if (bus.cw_out && bus.acw_out) n_excl <= n_excl + 1;
            if ((bus.cw_out && l_cw) || (bus.acw_out && l_acw) ||
                (bus.err_out && l_err) || (bus.btn_out && l_btn))
                n_wide <= n_wide + 1;
            l_cw  <= bus.cw_out;
            l_acw <= bus.acw_out;
            l_err <= bus.err_out;
            l_btn <= bus.btn_out;
        end
    end

    function automatic logic [1:0] cw_of(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] acw_of(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic add(input logic [1:0] ab, input logic c, input logic clr, input int cyc,
                       input int ecw, input int eacw, input int eerr, input int ebtn, input int epos);
        vec_t v;
        v.ab = ab; v.c = c; v.clr = clr; v.cyc = cyc;
        v.ecw = ecw; v.eacw = eacw; v.eerr = eerr; v.ebtn = ebtn; v.epos = epos;
        vecs.push_back(v);
    endtask

    task automatic add_cw();
        int p;
        p = 0;
        m_ab  = cw_of(m_ab);
        m_acc = m_acc + 1;
        if (m_acc == 4) begin
            p = 1; m_acc = 0;
            if (m_pos < 15) m_pos = m_pos + 1;
        end
        add(m_ab, 1'b0, 1'b0, 20, p, 0, 0, 0, m_pos);
    endtask

    task automatic add_acw();
        int p;
        p = 0;
        m_ab  = acw_of(m_ab);
        m_acc = m_acc - 1;
        if (m_acc == -4) begin
            p = 1; m_acc = 0;
            if (m_pos > 0) m_pos = m_pos - 1;
        end
        add(m_ab, 1'b0, 1'b0, 20, 0, p, 0, 0, m_pos);
    endtask

    task automatic add_clr();
        m_acc = 0; m_pos = 0;
        add(m_ab, 1'b0, 1'b1, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_vecs(input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            int s_cw, s_acw, s_err, s_btn;
            {bus.a_in, bus.b_in} = vecs[i].ab;
            bus.c_in   = vecs[i].c;
            bus.clr_in = vecs[i].clr;
            s_cw = n_cw; s_acw = n_acw; s_err = n_err; s_btn = n_btn;
            tick(vecs[i].cyc);
            bus.clr_in = 1'b0;
            check($sformatf("v%0d cw", i),  n_cw  - s_cw,  vecs[i].ecw);
            check($sformatf("v%0d acw", i), n_acw - s_acw, vecs[i].eacw);
            check($sformatf("v%0d err", i), n_err - s_err, vecs[i].eerr);
            check($sformatf("v%0d btn", i), n_btn - s_btn, vecs[i].ebtn);
            check($sformatf("v%0d pos", i), int'(bus.pos_out), vecs[i].epos);
        end
    endtask

    initial begin
        int s_cw, s_acw, lat;
        logic [1:0] t1_seq [4];

        rst_n = 1'b1;
        bus.a_in = 1'b1; bus.b_in = 1'b1; bus.c_in = 1'b0; bus.clr_in = 1'b0;

        // hand sequence 1 ends at AB=11, pos=1, acc=0
        m_ab = 2'b11; m_acc = 0; m_pos = 1;

        // glitches on A, never held long enough to be accepted
        for (int g = 0; g < 5; g++) begin
            add(2'b01, 1'b0, 1'b0, 3, 0, 0, 0, 0, 1);
            add(2'b11, 1'b0, 1'b0, 3, 0, 0, 0, 0, 1);
        end
        add(2'b11, 1'b0, 1'b0, 20, 0, 0, 0, 0, 1);
        // 20 CW detents from 0 saturate at 15, then one ACW detent
        add_clr();
        for (int k = 0; k < 80; k++) add_cw();
        for (int k = 0; k < 4; k++) add_acw();
        // partial step, illegal jump clears acc, then a clean detent
        add_cw();
        m_ab = ~m_ab; m_acc = 0;
        add(m_ab, 1'b0, 1'b0, 20, 0, 0, 1, 0, m_pos);
        for (int k = 0; k < 4; k++) add_cw();
        // unwind then a full detent, then three steps ahead of a cleared completion
        add_clr();
        add_cw(); add_cw(); add_acw(); add_acw();
        for (int k = 0; k < 4; k++) add_cw();
        for (int k = 0; k < 3; k++) add_cw();
        seg_a_end = vecs.size();
        hand_ab = cw_of(m_ab);
        m_ab = hand_ab; m_acc = 0; m_pos = 0;
        // accumulator must be empty after the clear
        for (int k = 0; k < 4; k++) add_cw();
        // button hold then release
        add(m_ab, 1'b1, 1'b0, 100, 0, 0, 0, 1, m_pos);
        add(m_ab, 1'b0, 1'b0, 20, 0, 0, 0, 0, m_pos);

        #1 rst_n = 1'b0;
        #2;
        check("rst cw",  int'(bus.cw_out), 0);
        check("rst acw", int'(bus.acw_out), 0);
        check("rst err", int'(bus.err_out), 0);
        check("rst btn", int'(bus.btn_out), 0);
        check("rst pos", int'(bus.pos_out), 0);
        #19 rst_n = 1'b1;
        tick(1);

        // four clean CW steps with latency check on the last
        t1_seq[0] = 2'b10; t1_seq[1] = 2'b00; t1_seq[2] = 2'b01; t1_seq[3] = 2'b11;
        for (int k = 0; k < 3; k++) begin
            {bus.a_in, bus.b_in} = t1_seq[k];
            s_cw = n_cw;
            tick(20);
            check($sformatf("t1 step%0d cw", k), n_cw - s_cw, 0);
        end
        {bus.a_in, bus.b_in} = t1_seq[3];
        s_cw = n_cw;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (bus.cw_out && lat < 0) lat = k;
        end
        check("t1 latency", lat, 11);
        check("t1 cw count", n_cw - s_cw, 1);
        check("t1 pos", int'(bus.pos_out), 1);

        run_vecs(0, seg_a_end);

        // clear coincides with the detent-completing cycle
        {bus.a_in, bus.b_in} = hand_ab;
        s_cw = n_cw; s_acw = n_acw;
        tick(10);
        bus.clr_in = 1'b1;
        tick(1);
        bus.clr_in = 1'b0;
        tick(9);
        check("clr cw", n_cw - s_cw, 0);
        check("clr acw", n_acw - s_acw, 0);
        check("clr pos", int'(bus.pos_out), 0);

        run_vecs(seg_a_end, vecs.size());

        // reset mid-debounce
        bus.c_in = 1'b1;
        tick(5);
        rst_n = 1'b0;
        #1;
        check("midrst cw",  int'(bus.cw_out), 0);
        check("midrst acw", int'(bus.acw_out), 0);
        check("midrst err", int'(bus.err_out), 0);
        check("midrst btn", int'(bus.btn_out), 0);
        check("midrst pos", int'(bus.pos_out), 0);

        check("cw/acw exclusive", n_excl, 0);
        check("pulse width", n_wide, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
